// File: rtl/rand_txn_gen_pkg.sv
// rtl/rand_txn_gen_pkg.sv - shared types, constants and LFSR step for the random transaction generator
package rand_txn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] SEED_DEF  = 32'hACE1_1234;

    // One right-shift Galois step; taps fold in when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] r);
        return (r >> 1) ^ (r[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/rand_txn_gen_if.sv
// rtl/rand_txn_gen_if.sv - transaction handshake bundle between generator and bus master
interface rand_txn_gen_if #(
    parameter int ADDR_W = 8
);
    logic              txn_valid;
    logic              txn_ready;
    logic [ADDR_W-1:0] txn_addr;
    logic              txn_wr;
    logic              txn_en;

    modport master (
        output txn_valid,
        output txn_addr,
        output txn_wr,
        output txn_en,
        input  txn_ready
    );

    modport slave (
        input  txn_valid,
        input  txn_addr,
        input  txn_wr,
        input  txn_en,
        output txn_ready
    );
endinterface

// File: rtl/rand_txn_gen_lfsr32_galois.sv
// rtl/rand_txn_gen_lfsr32_galois.sv - 32-bit Galois LFSR with load and step controls
module lfsr32_galois
    import rand_txn_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = SEED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        step,
    output logic [31:0] q
);
    logic [31:0] q_q;
    logic [31:0] q_d;

    // Load wins over step; a zero seed would lock the register, so it maps to the reset value.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (load_val == 32'h0) ? RESET_VAL : load_val;
        end else if (step) begin
            q_d = lfsr_step(q_q);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/rand_txn_gen.sv
// rtl/rand_txn_gen.sv - pseudo-random bus transaction generator: FSM, counters and field mapping
module rand_txn_gen
#(
    parameter int          ADDR_W   = 8,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] SEED_DEF = rand_txn_pkg::SEED_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       seed_in,
    input  logic [CNT_W-1:0]  num_txn,
    input  logic [ADDR_W-1:0] addr_min,
    input  logic [ADDR_W-1:0] addr_max,
    input  logic [8:0]        wr_thresh,
    input  logic [8:0]        en_thresh,
    rand_txn_gen_if.master    txn,
    output logic [CNT_W-1:0]  txn_count,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    import rand_txn_pkg::*;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_RUN  = RUN;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic [31:0]       lfsr_q;

    logic              range_bad;
    logic [ADDR_W-1:0] raw;
    logic [ADDR_W:0]   span;
    logic [2*ADDR_W:0] prod;
    logic [7:0]        wr_byte;
    logic [7:0]        en_byte;
    logic [ADDR_W-1:0] map_addr;
    logic              map_wr;
    logic              map_en;
    logic              accept;

    lfsr32_galois #(
        .RESET_VAL (SEED_DEF)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .load_val (seed_in),
        .step     (lfsr_adv),
        .q        (lfsr_q)
    );

    // Scale the raw LFSR bits into [addr_min, addr_max]; the product/shift keeps the result below span.
    always_comb begin
        range_bad = (addr_min > addr_max);
        raw       = ADDR_W'(lfsr_q);
        span      = {1'b0, addr_max} - {1'b0, addr_min} + (ADDR_W+1)'(1);
        prod      = (2*ADDR_W+1)'(raw) * (2*ADDR_W+1)'(span);
        map_addr  = range_bad ? addr_min : addr_min + ADDR_W'(prod >> ADDR_W);
        wr_byte   = 8'(lfsr_q >> 24);
        en_byte   = 8'(lfsr_q >> 16);
        map_wr    = ({1'b0, wr_byte} < wr_thresh);
        map_en    = ({1'b0, en_byte} < en_thresh);
    end

    // Run control: abort dominates; remaining==0 marks a continuous run and never decrements.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        en_d        = en_q;
        cfg_err_d   = cfg_err_q;
        done_d      = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;
        accept      = valid_q && txn.txn_ready;
        if (abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        lfsr_load   = 1'b1;
                        remaining_d = num_txn;
                        count_d     = '0;
                        cfg_err_d   = range_bad;
                        state_d     = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    addr_d   = map_addr;
                    wr_d     = map_wr;
                    en_d     = map_en;
                    lfsr_adv = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = ST_RUN;
                end
                ST_RUN: begin
                    if (accept) begin
                        count_d = count_q + CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            if (remaining_q != '0) begin
                                remaining_d = remaining_q - CNT_W'(1);
                            end
                            addr_d   = map_addr;
                            wr_d     = map_wr;
                            en_d     = map_en;
                            lfsr_adv = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            en_q        <= en_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign txn.txn_valid = valid_q;
    assign txn.txn_addr  = addr_q;
    assign txn.txn_wr    = wr_q;
    assign txn.txn_en    = en_q;
    assign txn_count     = count_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
endmodule

// File: tb/tb_rand_txn_gen.sv
// tb/tb_rand_txn_gen.sv - scoreboard bench for rand_txn_gen against a behavioural model
module tb_rand_txn_gen;
    localparam int          AW   = 8;
    localparam int          CW   = 16;
    localparam logic [31:0] SEED = 32'hACE1_1234;

    typedef struct packed {
        logic [7:0] addr;
        logic       wr;
        logic       en;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   seed_in = '0;
    logic [CW-1:0] num_txn = '0;
    logic [AW-1:0] addr_min = '0;
    logic [AW-1:0] addr_max = '0;
    logic [8:0]    wr_thresh = '0;
    logic [8:0]    en_thresh = '0;
    logic [CW-1:0] txn_count;
    logic          busy;
    logic          done;
    logic          cfg_err;

    rand_txn_gen_if #(.ADDR_W(AW)) txn_if ();

    rand_txn_gen #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .seed_in   (seed_in),
        .num_txn   (num_txn),
        .addr_min  (addr_min),
        .addr_max  (addr_max),
        .wr_thresh (wr_thresh),
        .en_thresh (en_thresh),
        .txn       (txn_if),
        .txn_count (txn_count),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    txn_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   ready_mode = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] r);
        logic [31:0] n;
        n = r / 2;
        if (r % 2 == 1) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // Expected transaction list straight from the arithmetic definition of each field.
    task automatic push_run(input logic [31:0] seed, input int n, input int mn, input int mx,
                            input int wt, input int et);
        logic [31:0] r;
        txn_t        t;
        int          a;
        r = (seed == 0) ? SEED : seed;
        for (int i = 0; i < n; i++) begin
            if (mn > mx) a = mn;
            else a = mn + (int'(r % 256) * (mx - mn + 1)) / 256;
            t.addr = a[7:0];
            t.wr   = (int'((r / 32'h0100_0000) % 256) < wt);
            t.en   = (int'((r / 32'h0001_0000) % 256) < et);
            exp_q.push_back(t);
            r = model_next(r);
        end
    endtask

    // Consumer ready: 0 = tied high, 1 = repeating 1-0-0-1, otherwise random.
    initial begin
        txn_if.txn_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       txn_if.txn_ready = 1'b1;
                1:       txn_if.txn_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: txn_if.txn_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: hold check under backpressure, scoreboard pop on every real accept.
    initial begin
        logic       pv;
        logic       pr;
        logic [9:0] pf;
        txn_t       e;
        pv = 1'b0;
        pr = 1'b0;
        pf = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (pv && !pr && txn_if.txn_valid)
                    check("hold_fields", {22'h0, txn_if.txn_addr, txn_if.txn_wr, txn_if.txn_en}, {22'h0, pf});
                if (txn_if.txn_valid && txn_if.txn_ready && !abort) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_txn: addr %0h with empty scoreboard at %0t", txn_if.txn_addr, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("txn_addr", 32'(txn_if.txn_addr), 32'(e.addr));
                        check("txn_wr", 32'(txn_if.txn_wr), 32'(e.wr));
                        check("txn_en", 32'(txn_if.txn_en), 32'(e.en));
                    end
                end
                pv = txn_if.txn_valid;
                pr = txn_if.txn_ready;
                pf = {txn_if.txn_addr, txn_if.txn_wr, txn_if.txn_en};
            end
        end
    end

    task automatic start_run(input logic [31:0] seed, input int n, input int mn, input int mx,
                             input int wt, input int et);
        seed_in   = seed;
        num_txn   = CW'(n);
        addr_min  = AW'(mn);
        addr_max  = AW'(mx);
        wr_thresh = 9'(wt);
        en_thresh = 9'(et);
        push_run(seed, n, mn, mx, wt, et);
        acc_cnt  = 0;
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n, input logic exp_err);
        int k;
        k = 0;
        while (!done && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'h1);
        check({tag, "_count"}, 32'(txn_count), 32'(n));
        check({tag, "_valid_low"}, 32'(txn_if.txn_valid), 32'h0);
        check({tag, "_busy_low"}, 32'(busy), 32'h0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'(exp_err));
        @(posedge clk);
        #1;
        check({tag, "_done_single"}, 32'(done_cnt), 32'h1);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcyc;
        int k;
        logic [CW-1:0] held;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(txn_if.txn_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(txn_count), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_cfg_err", 32'(cfg_err), 32'h0);
        check("rst_addr", 32'(txn_if.txn_addr), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a continuous bad-range run.
        ready_mode = 2;
        start_run(32'h1234_5678, 0, 8'h80, 8'h10, 128, 128);
        exp_q.delete();
        push_run(32'h1234_5678, 200, 8'h80, 8'h10, 128, 128);
        repeat (20) @(posedge clk);
        #1;
        check("mid_cfg_err", 32'(cfg_err), 32'h1);
        check("mid_valid", 32'(txn_if.txn_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(txn_if.txn_valid), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_count", 32'(txn_count), 32'h0);
        check("mrst_done", 32'(done), 32'h0);
        check("mrst_cfg_err", 32'(cfg_err), 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Counted run, ready tied high, exact timing.
        ready_mode = 0;
        start_run(32'h1, 5, 8'h00, 8'hFF, 100, 200);
        check("c2_load_no_valid", 32'(txn_if.txn_valid), 32'h0);
        @(posedge clk);
        #1;
        check("c2_first_valid", 32'(txn_if.txn_valid), 32'h1);
        vcyc = 0;
        k = 0;
        while (txn_if.txn_valid && k < 50) begin
            vcyc++;
            @(posedge clk);
            #1;
            k++;
        end
        check("c2_valid_cycles", 32'(vcyc), 32'h5);
        check("c2_done_after_last", 32'(done), 32'h1);
        check("c2_count", 32'(txn_count), 32'h5);
        @(posedge clk);
        #1;
        check("c2_done_pulse", 32'(done), 32'h0);
        check("c2_done_count", 32'(done_cnt), 32'h1);
        check("c2_sb_empty", 32'(exp_q.size()), 32'h0);

        // Same seed under 1-0-0-1 backpressure.
        ready_mode = 1;
        start_run(32'h1, 5, 8'h00, 8'hFF, 100, 200);
        wait_done("bp", 5, 1'b0);

        // Narrow range, never write, always enable.
        ready_mode = 2;
        start_run(32'hDEAD_BEEF, 200, 8'h40, 8'h4F, 0, 256);
        wait_done("thr", 200, 1'b0);

        // Inverted range pins the address to addr_min.
        start_run(32'h0BAD_F00D, 20, 8'h80, 8'h10, 128, 128);
        wait_done("bad", 20, 1'b1);

        // Continuous run from the default seed, then abort.
        ready_mode = 0;
        start_run(32'h0, 0, 8'h00, 8'hFF, 128, 64);
        exp_q.delete();
        push_run(32'h0, 400, 8'h00, 8'hFF, 128, 64);
        repeat (300) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("ab_valid_low", 32'(txn_if.txn_valid), 32'h0);
        check("ab_busy_low", 32'(busy), 32'h0);
        check("ab_count", 32'(txn_count), 32'(acc_cnt));
        held = txn_count;
        repeat (3) @(posedge clk);
        #1;
        check("ab_count_hold", 32'(txn_count), 32'(held));
        check("ab_no_done", 32'(done_cnt), 32'h0);
        exp_q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rand_txn_gen.md
Name: rand_txn_gen

Overview:
Synthesisable, parametrised generator of pseudo-random bus transactions (addr, wr, en) for on-chip stimulus and self-test.
- Driven by a 32-bit Galois LFSR.
- Supports address-range constraint, write/enable probability thresholds and a programmable transaction count.
- Delivers one transaction per accepted valid/ready handshake.
- Sits between a test controller (config/start) and the bus master under test.

Parameters:
ADDR_W, 8, address width; legal range 1..16
CNT_W, 16, width of transaction counters
SEED_DEF, 32'hACE1_1234, seed used at reset and whenever seed_in is zero

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a run when in IDLE, ignored otherwise
abort  in  1  ends the run from any state
seed_in  in  32  seed latched on start; zero selects SEED_DEF
num_txn  in  CNT_W  transactions per run; 0 = continuous
addr_min  in  ADDR_W  lower address bound, inclusive
addr_max  in  ADDR_W  upper address bound, inclusive
wr_thresh  in  9  wr=1 when byte < wr_thresh (0 = never, 256 = always)
en_thresh  in  9  en=1 when byte < en_thresh
txn_valid  out  1  transaction fields valid
txn_ready  in  1  consumer accepts
txn_addr  out  ADDR_W  generated address
txn_wr  out  1  generated write flag
txn_en  out  1  generated enable flag
txn_count  out  CNT_W  accepted transactions this run; wraps at 2^CNT_W
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a counted run completes
cfg_err  out  1  sticky per run: addr_min > addr_max seen at start

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, lfsr=SEED_DEF.
  - All outputs 0.
- LFSR:
  - Galois, right-shift, taps 32'h8020_0003.
  - Steps only where stated below.
  - A zero state is never loaded; seed 0 maps to SEED_DEF.
- Field derivation from current lfsr value r:
  - raw = r[ADDR_W-1:0]
  - span = addr_max - addr_min + 1, width ADDR_W+1
  - addr = addr_min + ((raw * span) >> ADDR_W), unsigned, never exceeds addr_max
  - wr = (r[31:24] < wr_thresh)
  - en = (r[23:16] < en_thresh)
  - If addr_min > addr_max: addr = addr_min and cfg_err set.
  - Config inputs must be stable while busy; sampled combinationally at each field update.
- FSM:
  - IDLE:
    - start=1 → lfsr <= (seed_in ? seed_in : SEED_DEF); remaining <= num_txn; txn_count <= 0; cfg_err <= (addr_min > addr_max).
    - Next state LOAD.
  - LOAD:
    - Fields <= f(lfsr); lfsr <= step(lfsr); txn_valid <= 1.
    - Next state RUN.
    - First txn_valid appears 2 cycles after start.
  - RUN:
    - Fields held stable while txn_valid && !txn_ready.
    - On accept: txn_count++.
      - Counted run with remaining==1: txn_valid <= 0; done <= 1 for one cycle; → IDLE.
      - Otherwise: remaining-- (counted runs only); fields <= f(lfsr); lfsr <= step; txn_valid stays 1.
    - Back-to-back accepts give one transaction per cycle.
- abort:
  - Highest priority over start and accept; valid in any state.
  - Effect next cycle: → IDLE, txn_valid <= 0, no done pulse.
  - txn_count and lfsr hold their values.
  - An accept in the same cycle as abort is not counted.
- Continuous mode (num_txn=0): runs until abort; txn_count wraps silently.
- IDLE outputs: txn_valid=0; fields keep their last values.
- Determinism: same seed and config give the same sequence regardless of ready timing.

Decomposition:
- Package rand_txn_pkg holds:
  - state enum {IDLE, LOAD, RUN}
  - LFSR_TAPS constant 32'h8020_0003
  - SEED_DEF default
  - function lfsr_step(logic [31:0])
- Sub-module lfsr32_galois:
  - Inputs: clk, rst_n, load, load_val, step.
  - Output: q.
  - Reset value is a parameter.
- Top module holds the FSM, counters and field mapping.

Test Plan:
1. Reset mid-run: rst_n low while txn_valid=1 → txn_valid, busy, txn_count, done and cfg_err all 0 immediately; state IDLE.
2. Counted run:
   - Stimulus: seed_in=32'h1, num_txn=5, ready tied 1.
   - Response: txn_valid high exactly 5 cycles starting start+2; done pulses once in the cycle after the 5th accept; txn_count=5.
   - Fields match the package-function reference model.
3. Backpressure:
   - Stimulus: ready toggling 1-0-0-1.
   - Response: fields constant whenever valid && !ready; sequence identical to scenario 2 with the same seed.
4. Thresholds and range:
   - Stimulus: addr_min=8'h40, addr_max=8'h4F, wr_thresh=0, en_thresh=256, 200 txns.
   - Response: every addr in 0x40..0x4F, wr=0, en=1, cfg_err=0.
5. Bad range:
   - Stimulus: addr_min=8'h80, addr_max=8'h10.
   - Response: cfg_err=1; every addr=8'h80.
6. Continuous mode and abort:
   - Stimulus: num_txn=0, seed_in=0, ready=1, abort after 300 cycles.
   - Response: no done pulse; txn_valid low the cycle after abort; first fields equal f(SEED_DEF); the accept coincident with abort is not counted.
